apu_register_interface: RTL and testbench

APU_REGISTER_INTERFACE -- requirements
Module: apu_register_interface

---
 rtl/apu_register_interface.sv | 175 +++++++++++++++++
 tb/tb_apu_register_interface.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_register_interface.sv
// APU register interface: decodes CPU writes to the rectangle channel
// registers, channel enable and frame control. It serves the 0x15 status
// read and runs the frame sequencer, which produces the envelope and
// length/sweep clocks and the frame interrupt flag.
module apu_register_interface #(
  parameter int FRAME_STEP = 7457
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iCpu_tick,
  input  logic [4:0]  iAddr,
  input  logic [7:0]  iData,
  input  logic        iWr,
  input  logic        iRd,
  input  logic [1:0]  iLength_active,
  output logic [7:0]  oData,
  output logic        oRd_valid,
  output logic [31:0] oRect1_regs,
  output logic [31:0] oRect2_regs,
  output logic [3:0]  oRect1_w,
  output logic [3:0]  oRect2_w,
  output logic [1:0]  oEnable,
  output logic        oEnvelope_clk,
  output logic        oLength_sweep_clk,
  output logic        oFrame_irq
);

  localparam logic [13:0] LP_DIV_LAST = 14'(FRAME_STEP - 1);
  localparam logic [4:0]  LP_ADDR_STATUS = 5'h15;
  localparam logic [4:0]  LP_ADDR_FRAME  = 5'h17;

  logic [3:0][7:0] r_rect1;
  logic [3:0][7:0] r_rect2;
  logic [3:0]      r_rect1_w;
  logic [3:0]      r_rect2_w;
  logic [1:0]      r_enable;
  logic [7:0]      r_rd_data;
  logic            r_rd_valid;
  logic            r_mode;
  logic            r_inhibit;
  logic [13:0]     r_div;
  logic [2:0]      r_step;
  logic            r_env_clk;
  logic            r_len_clk;
  logic            r_irq;

  logic            w_rd;
  logic            w_wr_frame;
  logic            w_terminal;
  logic [2:0]      w_step_last;
  logic [2:0]      w_step_next;
  logic            w_env_step;
  logic            w_len_step;
  logic            w_irq_step;
  logic            w_irq_set;
  logic            w_irq_clr;

  // A simultaneous write suppresses the read entirely.
  assign w_rd       = iRd & ~iWr;
  assign w_wr_frame = iWr && (iAddr == LP_ADDR_FRAME);
  assign w_terminal = iCpu_tick && (r_div == LP_DIV_LAST);

  // Step sequencing and the per-step pulse pattern for the current mode.
  always_comb begin
    w_step_last = r_mode ? 3'd5 : 3'd4;
    w_step_next = (r_step >= w_step_last) ? 3'd1 : r_step + 3'd1;
    w_env_step  = 1'b1;
    w_len_step  = 1'b0;
    w_irq_step  = 1'b0;
    if (r_mode) begin
      w_env_step = (w_step_next != 3'd4);
      w_len_step = (w_step_next == 3'd2) || (w_step_next == 3'd5);
    end else begin
      w_len_step = (w_step_next == 3'd2) || (w_step_next == 3'd4);
      w_irq_step = (w_step_next == 3'd4);
    end
  end

  // A frame-control write discards a coinciding step boundary, so it also
  // blocks the IRQ set; a set otherwise beats a status-read clear.
  assign w_irq_set = w_terminal & ~w_wr_frame & w_irq_step & ~r_inhibit;
  assign w_irq_clr = (w_wr_frame & iData[6]) | (w_rd && (iAddr == LP_ADDR_STATUS));

  // Register file writes with one-cycle per-register write strobes.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_rect1   <= '0;
      r_rect2   <= '0;
      r_rect1_w <= '0;
      r_rect2_w <= '0;
      r_enable  <= '0;
    end else begin
      r_rect1_w <= '0;
      r_rect2_w <= '0;
      if (iWr) begin
        if (iAddr[4:2] == 3'd0) begin
          r_rect1[iAddr[1:0]]   <= iData;
          r_rect1_w[iAddr[1:0]] <= 1'b1;
        end else if (iAddr[4:2] == 3'd1) begin
          r_rect2[iAddr[1:0]]   <= iData;
          r_rect2_w[iAddr[1:0]] <= 1'b1;
        end else if (iAddr == LP_ADDR_STATUS) begin
          r_enable <= iData[1:0];
        end
      end
    end
  end

  // Registered read port; only the status register returns nonzero data.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= (iAddr == LP_ADDR_STATUS) ?
                     {1'b0, r_irq, 4'b0000, iLength_active} : 8'h00;
      end
    end
  end

  // Frame divider, step counter and the one-cycle frame clocks.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_mode    <= 1'b0;
      r_inhibit <= 1'b0;
      r_div     <= '0;
      r_step    <= '0;
      r_env_clk <= 1'b0;
      r_len_clk <= 1'b0;
    end else if (w_wr_frame) begin
      r_mode    <= iData[7];
      r_inhibit <= iData[6];
      r_div     <= '0;
      r_step    <= '0;
      r_env_clk <= iData[7];
      r_len_clk <= iData[7];
    end else begin
      r_env_clk <= 1'b0;
      r_len_clk <= 1'b0;
      if (w_terminal) begin
        r_div     <= '0;
        r_step    <= w_step_next;
        r_env_clk <= w_env_step;
        r_len_clk <= w_len_step;
      end else if (iCpu_tick) begin
        r_div <= r_div + 14'd1;
      end
    end
  end

  // Frame interrupt flag.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end else if (w_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign oData             = r_rd_data;
  assign oRd_valid         = r_rd_valid;
  assign oRect1_regs       = r_rect1;
  assign oRect2_regs       = r_rect2;
  assign oRect1_w          = r_rect1_w;
  assign oRect2_w          = r_rect2_w;
  assign oEnable           = r_enable;
  assign oEnvelope_clk     = r_env_clk;
  assign oLength_sweep_clk = r_len_clk;
  assign oFrame_irq        = r_irq;

endmodule

// File: tb/tb_apu_register_interface.sv
// Scoreboard bench for apu_register_interface with a short frame step.
module tb_apu_register_interface;

  localparam int FS = 4;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iCpu_tick = 1'b0;
  logic [4:0]  iAddr = '0;
  logic [7:0]  iData = '0;
  logic        iWr = 1'b0;
  logic        iRd = 1'b0;
  logic [1:0]  iLength_active = '0;
  logic [7:0]  oData;
  logic        oRd_valid;
  logic [31:0] oRect1_regs;
  logic [31:0] oRect2_regs;
  logic [3:0]  oRect1_w;
  logic [3:0]  oRect2_w;
  logic [1:0]  oEnable;
  logic        oEnvelope_clk;
  logic        oLength_sweep_clk;
  logic        oFrame_irq;

  apu_register_interface #(.FRAME_STEP(FS)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iCpu_tick(iCpu_tick),
    .iAddr(iAddr), .iData(iData), .iWr(iWr), .iRd(iRd),
    .iLength_active(iLength_active), .oData(oData), .oRd_valid(oRd_valid),
    .oRect1_regs(oRect1_regs), .oRect2_regs(oRect2_regs),
    .oRect1_w(oRect1_w), .oRect2_w(oRect2_w), .oEnable(oEnable),
    .oEnvelope_clk(oEnvelope_clk), .oLength_sweep_clk(oLength_sweep_clk),
    .oFrame_irq(oFrame_irq)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int          cyc;
    logic [71:0] val;
  } exp_t;

  // Channel 0: reads, 1: write strobes, 2: frame clocks.
  exp_t q[3][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0][7:0] sh1 = '0;
  logic [3:0][7:0] sh2 = '0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic push(input int ch, input int c, input logic [71:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    q[ch].push_back(e);
  endtask

  task automatic mon_chan(input int ch, input bit present, input logic [71:0] act, input string nm);
    exp_t e;
    while (q[ch].size() > 0 && q[ch][0].cyc < cyc) begin
      e = q[ch].pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing: expected %h at cycle %0d, not observed", nm, e.val, e.cyc);
    end
    if (present) begin
      checks++;
      if (q[ch].size() == 0 || q[ch][0].cyc != cyc) begin
        errors++;
        $display("FAIL %s unexpected at cycle %0d: got %h", nm, cyc, act);
      end else begin
        e = q[ch].pop_front();
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, e.val);
        end
      end
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents an output.
  always @(negedge iClk) begin
    mon_chan(0, oRd_valid, {64'b0, oData}, "read");
    mon_chan(1, (oRect1_w != 4'b0) || (oRect2_w != 4'b0),
             {oRect2_w, oRect1_w, oRect2_regs, oRect1_regs}, "strobe");
    mon_chan(2, oEnvelope_clk || oLength_sweep_clk,
             {70'b0, oEnvelope_clk, oLength_sweep_clk}, "frame");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d, input bit with_rd);
    iWr = 1'b1;
    iRd = with_rd;
    iAddr = a;
    iData = d;
    if (a < 5'd4) begin
      sh1[a[1:0]] = d;
      push(1, cyc + 1, {4'b0, 4'b0001 << a[1:0], sh2, sh1});
    end else if (a < 5'd8) begin
      sh2[a[1:0]] = d;
      push(1, cyc + 1, {4'b0001 << a[1:0], 4'b0, sh2, sh1});
    end
    if (a == 5'h17 && d[7]) push(2, cyc + 1, 72'd3);
    tick();
    iWr = 1'b0;
    iRd = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp);
    iRd = 1'b1;
    iAddr = a;
    push(0, cyc + 1, {64'b0, exp});
    tick();
    iRd = 1'b0;
  endtask

  // Expected frame clocks for n steps after a frame write seen at cycle w.
  task automatic push_frame(input int w, input int n, input bit mode);
    int  s;
    bit  env;
    bit  len;
    for (int k = 1; k <= n; k++) begin
      s   = mode ? ((k - 1) % 5) + 1 : ((k - 1) % 4) + 1;
      env = mode ? (s != 4) : 1'b1;
      len = mode ? (s == 2 || s == 5) : (s == 2 || s == 4);
      if (env || len) push(2, w + FS * k, {70'b0, env, len});
    end
  endtask

  initial begin
    int w;
    repeat (3) tick();
    chk("reset oData", {24'b0, oData}, 32'h0);
    chk("reset oRd_valid", {31'b0, oRd_valid}, 32'h0);
    chk("reset rect regs", oRect1_regs | oRect2_regs, 32'h0);
    chk("reset enable/irq/clks", {27'b0, oEnable, oFrame_irq, oEnvelope_clk, oLength_sweep_clk}, 32'h0);
    iReset_n = 1'b1;
    tick();

    // Back-to-back writes, repeated writes, ignored offsets.
    wr(5'h02, 8'hAB, 1'b0);
    wr(5'h03, 8'h5C, 1'b0);
    tick();
    chk("rect1 regs", oRect1_regs, 32'h5CAB_0000);
    wr(5'h04, 8'h12, 1'b0);
    wr(5'h04, 8'h34, 1'b0);
    wr(5'h07, 8'h9E, 1'b0);
    wr(5'h10, 8'hFF, 1'b0);
    wr(5'h15, 8'h03, 1'b0);
    tick();
    chk("rect2 regs", oRect2_regs, 32'h9E00_0034);
    chk("enable", {30'b0, oEnable}, 32'h3);

    // Reads, and a write that swallows a simultaneous read.
    iLength_active = 2'b10;
    rd(5'h00, 8'h00);
    rd(5'h15, 8'h02);
    wr(5'h01, 8'h77, 1'b1);
    tick();

    // 4-step sequence, IRQ after 16 ticks, read clears it.
    iLength_active = 2'b00;
    iCpu_tick = 1'b1;
    wr(5'h17, 8'h00, 1'b0);
    w = cyc;
    push_frame(w, 4, 1'b0);
    repeat (16) tick();
    iCpu_tick = 1'b0;
    chk("irq after 16 ticks", {31'b0, oFrame_irq}, 32'h1);
    rd(5'h15, 8'h40);
    chk("irq cleared by read", {31'b0, oFrame_irq}, 32'h0);

    // Read on the same edge the IRQ gets set: set wins, read sees old value.
    iLength_active = 2'b01;
    iCpu_tick = 1'b1;
    wr(5'h17, 8'h00, 1'b0);
    w = cyc;
    push_frame(w, 4, 1'b0);
    repeat (15) tick();
    rd(5'h15, 8'h01);
    iCpu_tick = 1'b0;
    chk("irq set beats read clear", {31'b0, oFrame_irq}, 32'h1);
    rd(5'h15, 8'h41);
    chk("irq cleared after race", {31'b0, oFrame_irq}, 32'h0);

    // Inhibit write clears IRQ and keeps it clear for two sequences.
    iLength_active = 2'b00;
    iCpu_tick = 1'b1;
    wr(5'h17, 8'h00, 1'b0);
    w = cyc;
    push_frame(w, 4, 1'b0);
    repeat (16) tick();
    chk("irq before inhibit", {31'b0, oFrame_irq}, 32'h1);
    wr(5'h17, 8'h40, 1'b0);
    w = cyc;
    chk("irq cleared by inhibit", {31'b0, oFrame_irq}, 32'h0);
    push_frame(w, 8, 1'b0);
    repeat (32) tick();
    iCpu_tick = 1'b0;
    chk("irq stays clear inhibited", {31'b0, oFrame_irq}, 32'h0);

    // 5-step mode: immediate double pulse, then the 5-step pattern, no IRQ.
    iCpu_tick = 1'b1;
    wr(5'h17, 8'h80, 1'b0);
    w = cyc;
    push_frame(w, 10, 1'b1);
    repeat (40) tick();
    iCpu_tick = 1'b0;
    chk("no irq in 5-step mode", {31'b0, oFrame_irq}, 32'h0);

    // Frame write on a terminal tick discards that step boundary.
    iCpu_tick = 1'b1;
    wr(5'h17, 8'h00, 1'b0);
    w = cyc;
    push_frame(w, 1, 1'b0);
    repeat (7) tick();
    wr(5'h17, 8'h00, 1'b0);
    w = cyc;
    push_frame(w, 1, 1'b0);
    repeat (4) tick();
    iCpu_tick = 1'b0;
    repeat (3) tick();

    // Reset asserted while a write strobe is on the outputs.
    iLength_active = 2'b11;
    iWr = 1'b1;
    iAddr = 5'h00;
    iData = 8'h11;
    tick();
    iWr = 1'b0;
    iReset_n = 1'b0;
    #1;
    chk("reset aborts strobe", {24'b0, oRect1_w, oRect2_w}, 32'h0);
    chk("reset clears regs", oRect1_regs | oRect2_regs, 32'h0);
    chk("reset clears enable/data", {22'b0, oEnable, oData}, 32'h0);
    sh1 = '0;
    sh2 = '0;
    tick();
    tick();
    iReset_n = 1'b1;
    tick();
    rd(5'h15, 8'h03);
    repeat (4) tick();

    for (int ch = 0; ch < 3; ch++) chk("scoreboard drained", q[ch].size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
